// File: rtl/can_dt_classifier.sv
// CAN intrusion decision-tree classifier: walks a host-loaded node table
// one node per clock and reports class, error and saturating statistics.
module can_dt_classifier #(
  parameter int NODE_AW   = 8,
  parameter int CLASS_W   = 2,
  parameter int MAX_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [63:0]        feature_00,
  input  logic [63:0]        feature_01,
  input  logic [63:0]        feature_10,
  input  logic               features_ready,
  input  logic               cfg_we,
  input  logic [NODE_AW-1:0] cfg_addr,
  input  logic               cfg_is_leaf,
  input  logic [1:0]         cfg_feature_sel,
  input  logic [63:0]        cfg_threshold,
  input  logic [NODE_AW-1:0] cfg_left,
  input  logic [NODE_AW-1:0] cfg_right,
  input  logic [CLASS_W-1:0] cfg_class,
  output logic [CLASS_W-1:0] result_class,
  output logic               result_valid,
  output logic               result_error,
  output logic               busy,
  output logic [31:0]        frames_classified,
  output logic [31:0]        attacks_detected,
  output logic [31:0]        frames_dropped
);

  localparam int N  = 2**NODE_AW;
  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_LAST = DW'(MAX_DEPTH - 1);

  typedef enum logic {IDLE, EVAL} state_e;

  typedef struct packed {
    logic               is_leaf;
    logic [1:0]         sel;
    logic [63:0]        thr;
    logic [NODE_AW-1:0] left;
    logic [NODE_AW-1:0] right;
    logic [CLASS_W-1:0] cls;
  } node_t;

  localparam node_t NODE_RST =
    node_t'({1'b1, {($bits(node_t)-1){1'b0}}});

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  node_t              tbl_q [N];
  state_e             state_q, state_d;
  logic [NODE_AW-1:0] idx_q, idx_d;
  logic [DW-1:0]      depth_q, depth_d;
  logic [63:0]        f00_q, f00_d;
  logic [63:0]        f01_q, f01_d;
  logic [63:0]        f10_q, f10_d;
  logic [CLASS_W-1:0] cls_q, cls_d;
  logic               err_q, err_d;
  logic               valid_q, valid_d;
  logic [31:0]        fc_q, fc_d;
  logic [31:0]        ad_q, ad_d;
  logic [31:0]        fd_q, fd_d;

  node_t       cur;
  node_t       wr_node;
  logic        wr_en;
  logic [63:0] fsel;
  logic        go_right;

  assign cur     = tbl_q[idx_q];
  assign wr_en   = cfg_we && (state_q == IDLE) && !features_ready;
  assign wr_node = '{is_leaf: cfg_is_leaf, sel: cfg_feature_sel,
                     thr: cfg_threshold, left: cfg_left,
                     right: cfg_right, cls: cfg_class};

  always_comb begin
    fsel = '0;
    unique case (cur.sel)
      2'd0:    fsel = f00_q;
      2'd1:    fsel = f01_q;
      2'd2:    fsel = f10_q;
      default: fsel = '0;
    endcase
  end

  // Ties go left: only strictly greater selects the right child.
  assign go_right = fsel > cur.thr;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    depth_d = depth_q;
    f00_d   = f00_q;
    f01_d   = f01_q;
    f10_d   = f10_q;
    cls_d   = cls_q;
    err_d   = err_q;
    valid_d = 1'b0;
    fc_d    = fc_q;
    ad_d    = ad_q;
    fd_d    = fd_q;
    unique case (state_q)
      IDLE: begin
        if (features_ready) begin
          f00_d   = feature_00;
          f01_d   = feature_01;
          f10_d   = feature_10;
          idx_d   = '0;
          depth_d = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (features_ready) fd_d = sat_inc(fd_q);
        if (cur.is_leaf) begin
          cls_d   = cur.cls;
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = IDLE;
          fc_d    = sat_inc(fc_q);
          if (cur.cls != '0) ad_d = sat_inc(ad_q);
        end else if (cur.sel == 2'd3 || depth_q == DEPTH_LAST) begin
          cls_d   = '0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          state_d = IDLE;
          fc_d    = sat_inc(fc_q);
        end else begin
          idx_d   = go_right ? cur.right : cur.left;
          depth_d = depth_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      depth_q <= '0;
      f00_q   <= '0;
      f01_q   <= '0;
      f10_q   <= '0;
      cls_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      fc_q    <= '0;
      ad_q    <= '0;
      fd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      depth_q <= depth_d;
      f00_q   <= f00_d;
      f01_q   <= f01_d;
      f10_q   <= f10_d;
      cls_q   <= cls_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      fc_q    <= fc_d;
      ad_q    <= ad_d;
      fd_q    <= fd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) tbl_q[i] <= NODE_RST;
    end else if (wr_en) begin
      tbl_q[cfg_addr] <= wr_node;
    end
  end

  assign result_class      = cls_q;
  assign result_valid      = valid_q;
  assign result_error      = err_q;
  assign busy              = (state_q == EVAL);
  assign frames_classified = fc_q;
  assign attacks_detected  = ad_q;
  assign frames_dropped    = fd_q;

endmodule
